// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO that compacts
// partially valid fetch packets on entry and presents the oldest entries in program order.
module inst_buffer #(
   parameter int unsigned FETCH_WIDTH   = 2,
   parameter int unsigned PIPE_WIDTH    = 2,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned CPU_ADDR_BITS = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic                                  fetch_valid,
   input  logic [FETCH_WIDTH-1:0]                fetch_slot_valid,
   input  logic [FETCH_WIDTH*CPU_ADDR_BITS-1:0]  fetch_pc,
   input  logic [FETCH_WIDTH*32-1:0]             fetch_inst,
   output logic                                  fetch_ready,
   output logic [PIPE_WIDTH-1:0]                 dec_valid,
   output logic [PIPE_WIDTH*CPU_ADDR_BITS-1:0]   dec_pc,
   output logic [PIPE_WIDTH*32-1:0]              dec_inst,
   input  logic                                  dec_ready,
   output logic [$clog2(DEPTH+1)-1:0]            count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   localparam logic [CNT_W-1:0] PIPE_C      = CNT_W'(PIPE_WIDTH);
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] READY_LIM_C = CNT_W'(DEPTH - FETCH_WIDTH);

   logic [CPU_ADDR_BITS-1:0] r_pc   [DEPTH];
   logic [31:0]              r_inst [DEPTH];
   logic [PTR_W-1:0]         r_head;
   logic [PTR_W-1:0]         r_tail;
   logic [CNT_W-1:0]         r_count;

   logic                     w_enq;
   logic [CNT_W-1:0]         w_enq_cnt;
   logic [CNT_W-1:0]         w_enq_amt;
   logic [CNT_W-1:0]         w_deq_cnt;
   logic [CNT_W-1:0]         w_cnt_next;
   logic [PTR_W-1:0]         w_slot_ptr [FETCH_WIDTH];
   logic [PTR_W-1:0]         w_rd_ptr;
   logic [PIPE_WIDTH-1:0]    w_dv_inc;

   assign fetch_ready = (r_count <= READY_LIM_C);
   assign count       = r_count;
   assign w_enq       = fetch_valid && fetch_ready && !flush;

   // Each valid slot lands at tail plus the number of valid slots older than it.
   always_comb begin
      w_enq_cnt = '0;
      for (int unsigned s = 0; s < FETCH_WIDTH; s++) begin
         w_slot_ptr[s] = r_tail + w_enq_cnt[PTR_W-1:0];
         if (fetch_slot_valid[s]) begin
            w_enq_cnt = w_enq_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_enq_amt  = w_enq ? w_enq_cnt : '0;
      w_deq_cnt  = '0;
      if (dec_ready) begin
         w_deq_cnt = (r_count < PIPE_C) ? r_count : PIPE_C;
      end
      w_cnt_next = r_count + w_enq_amt - w_deq_cnt;
   end

   always_comb begin
      w_rd_ptr = '0;
      dec_valid = '0;
      dec_pc   = '0;
      dec_inst = '0;
      for (int unsigned i = 0; i < PIPE_WIDTH; i++) begin
         w_rd_ptr = r_head + PTR_W'(i);
         dec_valid[i] = (r_count > CNT_W'(i));
         dec_pc[i*CPU_ADDR_BITS +: CPU_ADDR_BITS] = r_pc[w_rd_ptr];
         dec_inst[i*32 +: 32] = r_inst[w_rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned e = 0; e < DEPTH; e++) begin
            r_pc[e]   <= '0;
            r_inst[e] <= '0;
         end
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            for (int unsigned s = 0; s < FETCH_WIDTH; s++) begin
               if (fetch_slot_valid[s]) begin
                  r_pc[w_slot_ptr[s]]   <= fetch_pc[s*CPU_ADDR_BITS +: CPU_ADDR_BITS];
                  r_inst[w_slot_ptr[s]] <= fetch_inst[s*32 +: 32];
               end
            end
         end
         r_tail  <= r_tail + w_enq_amt[PTR_W-1:0];
         r_head  <= r_head + w_deq_cnt[PTR_W-1:0];
         r_count <= w_cnt_next;
      end
   end

   assign w_dv_inc = dec_valid + PIPE_WIDTH'(1);

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= DEPTH_C);
   a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n)
      (dec_valid & w_dv_inc) == '0);

endmodule
